// File: rtl/wu_burst_sequencer.sv
// Wake-up burst sequencer: on a pending wake-up event, wait a fixed pre-delay,
// emit a burst of trigger pulses, then hand the event back with WU_serviced.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | no event in service, waiting for WU_valid
// S_DELAY   | pre-burst delay, DELAY_TICKS cycles
// S_PULSE_H | trig_out high phase of the current pulse
// S_PULSE_L | trig_out low phase of the current pulse
// S_ACK     | one-cycle WU_serviced, completed burst counted
// S_RELEASE | wait for the trigger stage to drop WU_valid before re-arming
module wu_burst_sequencer #(
   parameter int DELAY_TICKS  = 1000,
   parameter int PULSE_HI     = 50,
   parameter int PULSE_PERIOD = 200,
   parameter int NUM_PULSES   = 8
) (
   input  logic        clki,
   input  logic        rstn,
   input  logic        WU_valid,
   input  logic [19:0] count,
   output logic        WU_serviced,
   output logic        trig_out,
   output logic        busy,
   output logic [19:0] evt_id,
   output logic [15:0] done_count,
   output logic [15:0] abort_count
);

   localparam logic [15:0] DELAY_LAST = 16'((DELAY_TICKS > 0) ? DELAY_TICKS - 1 : 0);
   localparam logic [15:0] HI_LAST    = 16'(PULSE_HI - 1);
   localparam logic [15:0] LO_LAST    = 16'(PULSE_PERIOD - PULSE_HI - 1);
   localparam logic [7:0]  IDX_LAST   = 8'(NUM_PULSES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_DELAY,
      S_PULSE_H,
      S_PULSE_L,
      S_ACK,
      S_RELEASE
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] phase_q, phase_d;
   logic [7:0]  idx_q, idx_d;
   logic [19:0] evt_id_q, evt_id_d;
   logic [15:0] done_q, done_d;
   logic [15:0] abort_q, abort_d;
   logic        trig_q, trig_d;
   logic        busy_q, busy_d;
   logic        serviced_q, serviced_d;

   always_comb begin
      state_d  = state_q;
      phase_d  = phase_q + 16'd1;
      idx_d    = idx_q;
      evt_id_d = evt_id_q;
      done_d   = done_q;
      abort_d  = abort_q;

      case (state_q)
         S_IDLE: begin
            phase_d = '0;
            idx_d   = '0;
            if (WU_valid) begin
               evt_id_d = count;
               state_d  = (DELAY_TICKS == 0) ? S_PULSE_H : S_DELAY;
            end
         end
         S_DELAY: begin
            if (phase_q == DELAY_LAST) begin
               state_d = S_PULSE_H;
               phase_d = '0;
            end
         end
         S_PULSE_H: begin
            if (phase_q == HI_LAST) begin
               state_d = S_PULSE_L;
               phase_d = '0;
            end
         end
         S_PULSE_L: begin
            if (phase_q == LO_LAST) begin
               phase_d = '0;
               if (idx_q < IDX_LAST) begin
                  state_d = S_PULSE_H;
                  idx_d   = idx_q + 8'd1;
               end else begin
                  state_d = S_ACK;
               end
            end
         end
         S_ACK: begin
            // completion stands even if WU_valid drops in this cycle
            done_d  = done_q + 16'd1;
            state_d = S_RELEASE;
            phase_d = '0;
         end
         S_RELEASE: begin
            phase_d = '0;
            if (!WU_valid) state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            phase_d = '0;
         end
      endcase

      // trigger-stage timeout overrides any phase transition
      if (!WU_valid && (state_q == S_DELAY || state_q == S_PULSE_H || state_q == S_PULSE_L)) begin
         state_d = S_IDLE;
         phase_d = '0;
         idx_d   = '0;
         abort_d = abort_q + 16'd1;
      end

      trig_d     = (state_d == S_PULSE_H);
      busy_d     = (state_d != S_IDLE);
      serviced_d = (state_d == S_ACK);
   end

   always_ff @(posedge clki or negedge rstn) begin
      if (!rstn) begin
         state_q    <= S_IDLE;
         phase_q    <= '0;
         idx_q      <= '0;
         evt_id_q   <= '0;
         done_q     <= '0;
         abort_q    <= '0;
         trig_q     <= 1'b0;
         busy_q     <= 1'b0;
         serviced_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         phase_q    <= phase_d;
         idx_q      <= idx_d;
         evt_id_q   <= evt_id_d;
         done_q     <= done_d;
         abort_q    <= abort_d;
         trig_q     <= trig_d;
         busy_q     <= busy_d;
         serviced_q <= serviced_d;
      end
   end

   assign WU_serviced = serviced_q;
   assign trig_out    = trig_q;
   assign busy        = busy_q;
   assign evt_id      = evt_id_q;
   assign done_count  = done_q;
   assign abort_count = abort_q;

endmodule

// File: tb/tb_wu_burst_sequencer.sv
// Bench for wu_burst_sequencer: a default-parameter instance and a minimal
// instance, both checked every cycle against a timeline model of the burst.
module tb_wu_burst_sequencer;

   localparam int A_D = 1000, A_HI = 50, A_PP = 200, A_NP = 8;
   localparam int B_D = 0,    B_HI = 1,  B_PP = 2,   B_NP = 1;

   logic        clki = 1'b0;
   logic        rstn;
   logic        wu_a, wu_b;
   logic [19:0] cnt_a, cnt_b;
   logic        srv_a, srv_b, trig_a, trig_b, busy_a, busy_b;
   logic [19:0] evt_a, evt_b;
   logic [15:0] done_a, done_b, abort_a, abort_b;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_done[2];
   int exp_abort[2];

   logic        sel;
   logic        s_trig, s_busy, s_srv;
   logic [19:0] s_evt;
   logic [15:0] s_done, s_abort;

   always #5 clki = ~clki;

   wu_burst_sequencer #(.DELAY_TICKS(A_D), .PULSE_HI(A_HI), .PULSE_PERIOD(A_PP), .NUM_PULSES(A_NP)) dut_a (
      .clki(clki), .rstn(rstn), .WU_valid(wu_a), .count(cnt_a),
      .WU_serviced(srv_a), .trig_out(trig_a), .busy(busy_a),
      .evt_id(evt_a), .done_count(done_a), .abort_count(abort_a));

   wu_burst_sequencer #(.DELAY_TICKS(B_D), .PULSE_HI(B_HI), .PULSE_PERIOD(B_PP), .NUM_PULSES(B_NP)) dut_b (
      .clki(clki), .rstn(rstn), .WU_valid(wu_b), .count(cnt_b),
      .WU_serviced(srv_b), .trig_out(trig_b), .busy(busy_b),
      .evt_id(evt_b), .done_count(done_b), .abort_count(abort_b));

   always_comb begin
      s_trig  = sel ? trig_b  : trig_a;
      s_busy  = sel ? busy_b  : busy_a;
      s_srv   = sel ? srv_b   : srv_a;
      s_evt   = sel ? evt_b   : evt_a;
      s_done  = sel ? done_b  : done_a;
      s_abort = sel ? abort_b : abort_a;
   end

   task automatic set_inputs(input bit which, input logic wu, input logic [19:0] c);
      if (which) begin wu_b = wu; cnt_b = c; end
      else       begin wu_a = wu; cnt_a = c; end
   endtask

   // Called right after a negedge. WU_valid is first sampled high at the next
   // posedge (rel 0) and first sampled low at rel drop_rel.
   task automatic run_burst(input bit which, input int drop_rel, input logic [19:0] cval, input bit retrig);
      int d, hi, pp, np, p, end_rel, off;
      bit aborted;
      logic et, eb, es;
      logic [19:0] cur_c;
      d  = which ? B_D  : A_D;
      hi = which ? B_HI : A_HI;
      pp = which ? B_PP : A_PP;
      np = which ? B_NP : A_NP;
      p  = d + np * pp;
      aborted = (drop_rel <= p);
      end_rel = aborted ? drop_rel : ((drop_rel > p + 2) ? drop_rel : p + 2);
      cur_c = cval;
      sel = which;
      set_inputs(which, 1'b1, cur_c);
      for (int rel = 0; rel <= end_rel; rel++) begin
         @(posedge clki);
         #1;
         if (retrig && rel + 1 == 3) cur_c = cval + 20'd1;
         set_inputs(which, (rel + 1 >= drop_rel) ? 1'b0 : 1'b1, cur_c);
         @(negedge clki);
         off = rel - d;
         et = (rel < end_rel) && (off >= 0) && (off < np * pp) && ((off % pp) < hi);
         eb = (rel < end_rel);
         es = !aborted && (rel == p);
         n_checks += 4;
         if (s_trig !== et) begin n_fail++; $display("FAIL trig dut%0d rel=%0d got=%b exp=%b", which, rel, s_trig, et); end
         if (s_busy !== eb) begin n_fail++; $display("FAIL busy dut%0d rel=%0d got=%b exp=%b", which, rel, s_busy, eb); end
         if (s_srv !== es)  begin n_fail++; $display("FAIL serviced dut%0d rel=%0d got=%b exp=%b", which, rel, s_srv, es); end
         if (s_evt !== cval) begin n_fail++; $display("FAIL evt_id dut%0d rel=%0d got=%0d exp=%0d", which, rel, s_evt, cval); end
      end
      if (aborted) exp_abort[which]++;
      else         exp_done[which]++;
      n_checks += 2;
      if (s_done !== 16'(exp_done[which]))
         begin n_fail++; $display("FAIL done_count dut%0d got=%0d exp=%0d", which, s_done, exp_done[which]); end
      if (s_abort !== 16'(exp_abort[which]))
         begin n_fail++; $display("FAIL abort_count dut%0d got=%0d exp=%0d", which, s_abort, exp_abort[which]); end
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      set_inputs(0, 1'b1, 20'd5);
      set_inputs(1, 1'b0, 20'd0);
      repeat (3) @(negedge clki);
      n_checks += 2;
      if ({srv_a, trig_a, busy_a, evt_a, done_a, abort_a} !== '0)
         begin n_fail++; $display("FAIL reset_outputs_a got=%h exp=0", {srv_a, trig_a, busy_a, evt_a, done_a, abort_a}); end
      if ({srv_b, trig_b, busy_b, evt_b, done_b, abort_b} !== '0)
         begin n_fail++; $display("FAIL reset_outputs_b got=%h exp=0", {srv_b, trig_b, busy_b, evt_b, done_b, abort_b}); end
      rstn = 1'b1;
      run_burst(0, A_D + A_NP * A_PP + 2, 20'd5, 0);
   endtask

   task automatic test_nominal();
      run_burst(0, A_D + A_NP * A_PP + 1, 20'd3, 0);
   endtask

   task automatic test_abort();
      run_burst(0, A_D + 3 * A_PP + 20, 20'd7, 0);
   endtask

   task automatic test_retrigger();
      run_burst(0, A_D + A_NP * A_PP + 1, 20'd3, 1);
   endtask

   task automatic test_held_valid();
      run_burst(0, A_D + A_NP * A_PP + 21, 20'd11, 0);
      run_burst(0, A_D + A_NP * A_PP + 1, 20'd12, 0);
   endtask

   task automatic test_min_config();
      run_burst(1, 3, 20'd21, 0);
      run_burst(1, 3, 20'd22, 0);
      run_burst(1, 1, 20'd23, 0);
   endtask

   task automatic test_random();
      int p, drop;
      for (int i = 0; i < 5; i++) begin
         p = A_D + A_NP * A_PP;
         drop = ($urandom_range(0, 1) == 1) ? $urandom_range(1, p) : $urandom_range(p + 1, p + 30);
         run_burst(0, drop, 20'($urandom), 1'($urandom_range(0, 1)));
      end
      for (int i = 0; i < 25; i++) begin
         run_burst(1, $urandom_range(1, 8), 20'($urandom), 1'($urandom_range(0, 1)));
      end
   endtask

   task automatic test_reset_mid_burst();
      sel = 0;
      set_inputs(0, 1'b1, 20'd9);
      repeat (A_D + 20) @(posedge clki);
      #2;
      n_checks += 1;
      if (trig_a !== 1'b1) begin n_fail++; $display("FAIL pre_reset_trig got=%b exp=1", trig_a); end
      rstn = 1'b0;
      #1;
      n_checks += 1;
      if ({srv_a, trig_a, busy_a, evt_a, done_a, abort_a} !== '0)
         begin n_fail++; $display("FAIL async_reset_a got=%h exp=0", {srv_a, trig_a, busy_a, evt_a, done_a, abort_a}); end
      set_inputs(0, 1'b0, 20'd9);
      exp_done  = '{0, 0};
      exp_abort = '{0, 0};
      @(negedge clki);
      rstn = 1'b1;
      repeat (5) begin
         @(negedge clki);
         n_checks += 1;
         if (busy_a !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle got=%b exp=0", busy_a); end
      end
      run_burst(1, 3, 20'd30, 0);
   endtask

   initial begin
      exp_done  = '{0, 0};
      exp_abort = '{0, 0};
      sel = 0;
      test_reset();
      test_nominal();
      test_abort();
      test_retrigger();
      test_held_valid();
      test_min_config();
      test_random();
      test_reset_mid_burst();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
